// File: rtl/watchdog_cpu_sys_debug_mem_arbiter.sv
// -----------------------------------------------------------------------------
// watchdog_cpu_sys_debug_mem_arbiter
//
// Purpose:
//   Shares the single-port on-chip debug memory (OCI RAM) between two
//   requesters in the system clock domain:
//     * the JTAG debug-slave command path (one-cycle command strobes), and
//     * the CPU-side Avalon-MM debug slave.
//   Every access runs through a fixed IDLE -> ACCESS -> CAPTURE -> DONE
//   sequence (4 cycles, reads and writes alike). When the CPU is halted in
//   debug mode (debugack = 1) the JTAG side has absolute priority; otherwise
//   simultaneous requests are served round-robin.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   debugack            CPU halted in debug mode (JTAG priority when 1)
//   jtag_req/wr/addr/wdata   JTAG command strobe and its sampled fields
//   jtag_done           one-cycle completion pulse for a JTAG command
//   jtag_rdata          JTAG read result, held until the next JTAG read
//   jtag_overrun        sticky: a JTAG command arrived while one was pending
//   cpu_read/write/address/writedata   Avalon-MM slave request
//   cpu_waitrequest     Avalon waitrequest (low for one cycle per access)
//   cpu_readdata        Avalon read data, valid with waitrequest low on reads
//   mem_en/we/addr/wdata  registered memory controls
//   mem_rdata           synchronous memory read data (cycle after mem_en)
//   busy                sequencer not idle
// -----------------------------------------------------------------------------
module watchdog_cpu_sys_debug_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              debugack,
  // JTAG command path
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_done,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_overrun,
  // CPU Avalon-MM slave
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  // Debug memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Pending JTAG command (single-entry holding register)
  logic              pend_q, pend_d;
  logic              jwr_q, jwr_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic [DATA_W-1:0] jwdata_q, jwdata_d;
  logic              overrun_q, overrun_d;

  // Access ownership; owner/last grant encoded as 1 = JTAG, 0 = CPU
  logic              owner_jtag_q, owner_jtag_d;
  logic              last_jtag_q, last_jtag_d;
  // Direction of the access in flight; mem_we itself only lasts one cycle
  logic              acc_wr_q, acc_wr_d;

  // Registered memory interface
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Per-requester read-data registers
  logic [DATA_W-1:0] jtag_rdata_q, jtag_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic cpu_req;
  logic grant_jtag;

  assign cpu_req = cpu_read | cpu_write;

  // JTAG wins when it is the only requester, when the CPU is halted in debug
  // mode, or when the previous grant went to the CPU (round-robin).
  assign grant_jtag = pend_q & (~cpu_req | debugack | ~last_jtag_q);

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    jwr_d        = jwr_q;
    jaddr_d      = jaddr_q;
    jwdata_d     = jwdata_q;
    overrun_d    = overrun_q;
    owner_jtag_d = owner_jtag_q;
    last_jtag_d  = last_jtag_q;
    acc_wr_d     = acc_wr_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    jtag_rdata_d = jtag_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q || cpu_req) begin
          owner_jtag_d = grant_jtag;
          last_jtag_d  = grant_jtag;
          if (grant_jtag) begin
            acc_wr_d    = jwr_q;
            mem_we_d    = jwr_q;
            mem_addr_d  = jaddr_q;
            mem_wdata_d = jwdata_q;
          end else begin
            // Read+write together counts as a write
            acc_wr_d    = cpu_write;
            mem_we_d    = cpu_write;
            mem_addr_d  = cpu_address;
            mem_wdata_d = cpu_writedata;
          end
          mem_en_d = 1'b1;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // Memory output is valid in the cycle following the enable
        if (!acc_wr_q) begin
          if (owner_jtag_q) begin
            jtag_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (owner_jtag_q) begin
          pend_d = 1'b0;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Capture decisions look at the registered pending flag, so a strobe in
    // the very cycle the pending command completes is still an overrun.
    if (jtag_req) begin
      if (pend_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d   = 1'b1;
        jwr_d    = jtag_wr;
        jaddr_d  = jtag_addr;
        jwdata_d = jtag_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= 1'b0;
      jwr_q        <= 1'b0;
      jaddr_q      <= '0;
      jwdata_q     <= '0;
      overrun_q    <= 1'b0;
      owner_jtag_q <= 1'b0;
      last_jtag_q  <= 1'b0;
      acc_wr_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      jtag_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      jwr_q        <= jwr_d;
      jaddr_q      <= jaddr_d;
      jwdata_q     <= jwdata_d;
      overrun_q    <= overrun_d;
      owner_jtag_q <= owner_jtag_d;
      last_jtag_q  <= last_jtag_d;
      acc_wr_q     <= acc_wr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      jtag_rdata_q <= jtag_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Completion signalling is decoded from the state register so an
  // asynchronous reset removes it in the same instant.
  assign jtag_done       = (state_q == ST_DONE) &  owner_jtag_q;
  assign cpu_waitrequest = ~((state_q == ST_DONE) & ~owner_jtag_q);
  assign busy            = (state_q != ST_IDLE);

  assign jtag_rdata   = jtag_rdata_q;
  assign jtag_overrun = overrun_q;
  assign cpu_readdata = cpu_rdata_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_watchdog_cpu_sys_debug_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for watchdog_cpu_sys_debug_mem_arbiter.
// A transaction-level model (age of the access in flight, pending JTAG
// command, golden memory, grant log) predicts every output each cycle; a
// few hand-computed literals pin the model on the directed scenarios.
// -----------------------------------------------------------------------------
module tb_watchdog_cpu_sys_debug_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          debugack = 1'b0;
  logic          jtag_req = 1'b0;
  logic          jtag_wr = 1'b0;
  logic [AW-1:0] jtag_addr = '0;
  logic [DW-1:0] jtag_wdata = '0;
  logic          jtag_done;
  logic [DW-1:0] jtag_rdata;
  logic          jtag_overrun;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic [DW-1:0] cpu_writedata = '0;
  logic          cpu_waitrequest;
  logic [DW-1:0] cpu_readdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  watchdog_cpu_sys_debug_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .debugack(debugack),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr),
    .jtag_wdata(jtag_wdata), .jtag_done(jtag_done), .jtag_rdata(jtag_rdata),
    .jtag_overrun(jtag_overrun),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Environment: synchronous single-port RAM
  logic [DW-1:0] ram [256];
  logic [DW-1:0] golden [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      golden[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    int            t;      // 0 = no access; else cycles since grant (1..3)
    bit            pend;
    bit            pw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    bit            own_j;
    bit            last_j;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            over;
    logic [DW-1:0] jrd;
    logic [DW-1:0] crd;
  } mstate_t;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.t = 0; s.pend = 0; s.pw = 0; s.pa = '0; s.pd = '0;
    s.own_j = 0; s.last_j = 0; s.wr = 0; s.addr = '0; s.wd = '0;
    s.over = 0; s.jrd = '0; s.crd = '0;
    return s;
  endfunction

  // Arbitration rule written out plainly
  function automatic bit jtag_wins(input mstate_t s);
    if (!s.pend) return 1'b0;
    if (!(cpu_read || cpu_write)) return 1'b1;
    if (debugack) return 1'b1;
    return !s.last_j;
  endfunction

  function automatic mstate_t model_step(input mstate_t s);
    mstate_t n = s;
    if (s.t == 0) begin
      if (s.pend || cpu_read || cpu_write) begin
        n.own_j  = jtag_wins(s);
        n.last_j = n.own_j;
        if (n.own_j) begin
          n.wr = s.pw; n.addr = s.pa; n.wd = s.pd;
        end else begin
          n.wr = cpu_write; n.addr = cpu_address; n.wd = cpu_writedata;
        end
        n.t = 1;
      end
    end else if (s.t == 3) begin
      if (s.own_j) n.pend = 0;
      n.t = 0;
    end else begin
      if (s.t == 2 && !s.wr) begin
        if (s.own_j) n.jrd = golden[s.addr];
        else         n.crd = golden[s.addr];
      end
      n.t = s.t + 1;
    end
    if (jtag_req) begin
      if (s.pend) n.over = 1;
      else begin
        n.pend = 1; n.pw = jtag_wr; n.pa = jtag_addr; n.pd = jtag_wdata;
      end
    end
    return n;
  endfunction

  mstate_t m = reset_state();
  bit      grant_log [$];
  int      cycle_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= reset_state();
    else          m <= model_step(m);
  end

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (reset_n && m.t == 0 && (m.pend || cpu_read || cpu_write))
      grant_log.push_back(jtag_wins(m));
    if (reset_n && m.t == 1 && m.wr)
      golden[m.addr] <= m.wd;
  end

  // ---------------------------------------------------------------- checks
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int wr_low_cnt = 0;
  int wr_low_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy, m.t != 0);
      chk("mem_en", mem_en, m.t == 1);
      chk("mem_we", mem_we, m.t == 1 && m.wr);
      if (m.t == 1) begin
        chk("mem_addr", mem_addr, m.addr);
        if (m.wr) chk("mem_wdata", mem_wdata, m.wd);
      end
      chk("jtag_done", jtag_done, m.t == 3 && m.own_j);
      chk("cpu_waitrequest", cpu_waitrequest, !(m.t == 3 && !m.own_j));
      chk("jtag_rdata", jtag_rdata, m.jrd);
      chk("cpu_readdata", cpu_readdata, m.crd);
      chk("jtag_overrun", jtag_overrun, m.over);
      if (jtag_done) begin done_cnt++; last_done_cyc = cycle_cnt; end
      if (!cpu_waitrequest) begin wr_low_cnt++; wr_low_cyc = cycle_cnt; end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jreq(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    jtag_req = 1'b1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
    cyc(1);
    jtag_req = 1'b0;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    int r;
    int d0;
    bit exp_seq [4];
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};

    cyc(3);
    chk("reset_waitrequest", cpu_waitrequest, 1);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    cyc(2);

    // JTAG write then read of 0x10
    r = cycle_cnt;
    jreq(1'b1, 8'h10, 32'hDEADBEEF);
    cyc(6);
    chk("t1_write_done_count", done_cnt, 1);
    chk("t1_write_done_latency", last_done_cyc - r, 4);
    jreq(1'b0, 8'h10, 32'h0);
    cyc(6);
    chk("t1_read_done_count", done_cnt, 2);
    chk("t1_jtag_rdata", jtag_rdata, 32'hDEADBEEF);
    $display("jtag write/read 0x10 complete, rdata=%h", jtag_rdata);

    // Lone CPU read of 0x10
    r = cycle_cnt;
    cpu_read = 1'b1; cpu_address = 8'h10;
    cyc(4);
    cpu_read = 1'b0;
    cyc(3);
    chk("t2_waitreq_low_cycles", wr_low_cnt, 1);
    chk("t2_waitreq_low_offset", wr_low_cyc - r, 3);
    chk("t2_cpu_readdata", cpu_readdata, 32'hDEADBEEF);
    $display("cpu read 0x10 complete, readdata=%h", cpu_readdata);

    // Contention, debugack = 0: round-robin starting with JTAG
    reset_pulse();
    grant_log.delete();
    debugack = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) begin
        jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h10;
      end else begin
        jtag_req = 1'b0;
      end
      if (k >= 1) begin
        cpu_write = 1'b1; cpu_address = 8'h20; cpu_writedata = 32'hC0DE0000 + k;
      end
      cyc(1);
    end
    jtag_req = 1'b0; cpu_write = 1'b0;
    cyc(8);
    chk("t3_grant_count_ge4", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("t3_grant_order", grant_log[i], exp_seq[i]);
    $display("contention debugack=0: %0d grants logged", grant_log.size());

    // debugack = 1: JTAG wins even though it had the last grant
    jreq(1'b1, 8'h40, 32'h0000_4040);
    cyc(6);
    grant_log.delete();
    debugack = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) begin
        jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h40;
      end else begin
        jtag_req = 1'b0;
      end
      if (k >= 1) begin
        cpu_write = 1'b1; cpu_address = 8'h50; cpu_writedata = 32'h5050_0000 + k;
      end
      cyc(1);
    end
    jtag_req = 1'b0; cpu_write = 1'b0; debugack = 1'b0;
    cyc(8);
    chk("t4_grant_count_ge2", grant_log.size() >= 2, 1);
    if (grant_log.size() >= 2) begin
      chk("t4_first_grant_jtag", grant_log[0], 1);
      chk("t4_second_grant_cpu", grant_log[1], 0);
    end
    chk("t4_jtag_rdata", jtag_rdata, 32'h0000_4040);
    $display("contention debugack=1: %0d grants logged", grant_log.size());

    // Overrun: second strobe two cycles after the first
    reset_pulse();
    d0 = done_cnt;
    jreq(1'b1, 8'h30, 32'h5555AAAA);
    cyc(1);
    jreq(1'b1, 8'h31, 32'h11111111);
    cyc(8);
    chk("t5_single_done", done_cnt - d0, 1);
    chk("t5_overrun", jtag_overrun, 1);
    $display("overrun scenario complete, overrun=%0b", jtag_overrun);

    // Reset asserted during ACCESS of a JTAG write
    d0 = done_cnt;
    jreq(1'b1, 8'h60, 32'hBAD00001);
    cyc(1);
    chk("t6_in_access", mem_en, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_mem_en_drop", mem_en, 0);
    chk("t6_mem_we_drop", mem_we, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(6);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_busy", busy, 0);
    chk("t6_waitrequest", cpu_waitrequest, 1);
    jreq(1'b0, 8'h60, 32'h0);
    cyc(6);
    chk("t6_write_aborted", jtag_rdata, 32'h0);
    $display("reset-during-access scenario complete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
